// File: rtl/demo_trace_pkg.sv
// ---------------------------------------------------------------------------
// demo_trace_pkg
// Shared types and default sizing for the demo trace capture block.
//   state_t    : capture FSM state encoding (IDLE/PRE/POST/DUMP)
//   DEF_WIDTH  : default sample width (matches the demo counter)
//   DEF_DEPTH  : default buffer depth (power of two, >= 4)
// ---------------------------------------------------------------------------
package demo_trace_pkg;

   localparam int DEF_WIDTH = 6;
   localparam int DEF_DEPTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_POST = 2'd2,
      ST_DUMP = 2'd3
   } state_t;

endpackage

// File: rtl/demo_trace_ram.sv
// ---------------------------------------------------------------------------
// demo_trace_ram
// DEPTH x WIDTH register array used as the circular trace buffer.
//   clk_i    : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data, combinational from raddr_i
// Contents are intentionally not reset.
// ---------------------------------------------------------------------------
module demo_trace_ram #(
   parameter  int WIDTH = 6,
   parameter  int DEPTH = 16,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [PW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [PW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/demo_trace_capture.sv
// ---------------------------------------------------------------------------
// demo_trace_capture
// Samples the demo counter into a circular pre-trigger buffer, triggers on a
// programmed value, collects a programmed number of post-trigger samples and
// then dumps the captured window oldest-first.
//   clk, rst_n        : clock (rising edge), async active-low reset
//   arm               : start a capture (IDLE only); latches trig_value/post_count
//   abort             : synchronous return to IDLE, highest priority
//   trig_value        : trigger match value
//   post_count        : number of samples to keep after the trigger sample
//   sample_valid/sample : counter stream being observed
//   triggered         : one-cycle pulse after the trigger sample is written
//   busy              : FSM not in IDLE
//   out_valid/out_ready/out_data/out_last : dump stream
//   dbg_state         : current FSM state (state_t encoding)
//
// Dump stream handshake: a beat transfers on a rising edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low,
// out_data and out_last hold; out_valid never drops without a transfer except
// on abort or reset.
// ---------------------------------------------------------------------------
module demo_trace_capture
   import demo_trace_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int DEPTH = DEF_DEPTH,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             arm,
   input  logic             abort,
   input  logic [WIDTH-1:0] trig_value,
   input  logic [PW-1:0]    post_count,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] sample,
   output logic             triggered,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic [1:0]       dbg_state
);

   localparam logic [PW:0] FILL_MAX = (PW+1)'(DEPTH);

   state_t           state_q;
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW:0]      fill_q;
   logic [PW:0]      left_q;       // beats still to send, including current
   logic [PW-1:0]    remaining_q;
   logic [PW-1:0]    post_q;
   logic [WIDTH-1:0] trig_q;
   logic             triggered_q;
   logic             out_valid_q;
   logic             out_last_q;

   logic [PW-1:0]    wr_ptr_d;
   logic [PW:0]      fill_d;
   logic [PW-1:0]    dump_ptr_d;
   logic             capturing;
   logic             wr_en;
   logic             hit;
   logic             capture_done;
   logic [WIDTH-1:0] ram_rdata;

   assign capturing = (state_q == ST_PRE) || (state_q == ST_POST);
   assign wr_en     = capturing && sample_valid && !abort;
   assign hit       = (sample == trig_q);

   // Pointer is exactly PW bits wide, so the increment wraps modulo DEPTH.
   assign wr_ptr_d   = wr_ptr_q + 1'b1;
   assign fill_d     = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
   // Oldest entry after this write; when full the low bits of fill are zero
   // and the oldest entry is the one about to be overwritten next.
   assign dump_ptr_d = wr_ptr_d - fill_d[PW-1:0];

   // This write is the last one of the capture window.
   assign capture_done = sample_valid &&
                         (((state_q == ST_PRE) && hit && (post_q == '0)) ||
                          ((state_q == ST_POST) && (remaining_q == PW'(1))));

   demo_trace_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i (sample),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fill_q      <= '0;
         left_q      <= '0;
         remaining_q <= '0;
         post_q      <= '0;
         trig_q      <= '0;
         triggered_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         triggered_q <= 1'b0;
         if (abort) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (arm) begin
                     trig_q   <= trig_value;
                     // post_count is PW bits, so it can never exceed DEPTH-1:
                     // the trigger sample always stays inside the window.
                     post_q   <= post_count;
                     wr_ptr_q <= '0;
                     fill_q   <= '0;
                     state_q  <= ST_PRE;
                  end
               end
               ST_PRE, ST_POST: begin
                  if (sample_valid) begin
                     wr_ptr_q <= wr_ptr_d;
                     fill_q   <= fill_d;
                     if ((state_q == ST_PRE) && hit) begin
                        triggered_q <= 1'b1;
                     end
                     if (capture_done) begin
                        state_q     <= ST_DUMP;
                        remaining_q <= '0;
                        rd_ptr_q    <= dump_ptr_d;
                        left_q      <= fill_d;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (fill_d == (PW+1)'(1));
                     end else if ((state_q == ST_PRE) && hit) begin
                        remaining_q <= post_q;
                        state_q     <= ST_POST;
                     end else if (state_q == ST_POST) begin
                        remaining_q <= remaining_q - 1'b1;
                     end
                  end
               end
               ST_DUMP: begin
                  if (out_ready) begin
                     if (out_last_q) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                     end else begin
                        rd_ptr_q   <= rd_ptr_q + 1'b1;
                        left_q     <= left_q - 1'b1;
                        out_last_q <= (left_q == (PW+1)'(2));
                     end
                  end
               end
               default: begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign triggered = triggered_q;
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   // Buffer contents are not reset, so gate the read data outside DUMP.
   assign out_data  = out_valid_q ? ram_rdata : '0;
   assign dbg_state = state_q;

endmodule
